// File: rtl/sm_accumulator_if.sv
// Handshake bundle for sm_accumulator: operand stream in, reduced result out.
// master drives operands and out_ready; slave is the accumulator side.
interface sm_accumulator_if #(
    parameter int unsigned N  = 32,
    parameter int unsigned CW = 8
) ();
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          out_zero;
    logic          out_neg;
    logic          out_sat;
    logic [CW-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_neg, out_sat, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_neg, out_sat, out_count
    );
endinterface

// File: rtl/sm_accumulator.sv
// Streaming sign-magnitude accumulator: sums a valid/ready burst, presents the result on last.
// Define SM_ACC_SAT_EN to clamp the magnitude on overflow instead of wrapping it.
module sm_accumulator #(
    parameter int unsigned N  = 32,
    parameter int unsigned CW = 8
) (
    input logic             clk,
    input logic             rst,
    sm_accumulator_if.slave bus
);
    typedef enum logic [0:0] {StAcc, StOut} state_e;

    state_e        r_state;
    logic          r_acc_sign;
    logic [14:0]   r_acc_mag;
    logic [CW-1:0] r_count;
    logic          r_sat;
    logic [N-1:0]  r_out_data;
    logic          r_out_zero;
    logic          r_out_neg;
    logic          r_out_sat;
    logic [CW-1:0] r_out_count;

    logic          w_op_sign;
    logic [14:0]   w_op_mag;
    logic          w_sum_sign;
    logic [14:0]   w_sum_mag;
    logic          w_sat_next;
    logic [CW-1:0] w_cnt_next;
`ifdef SM_ACC_SAT_EN
    logic [15:0]   w_add;
`else
    logic [14:0]   w_add;
`endif

    if (N > 16) begin : g_upper
        logic w_unused_upper;
        assign w_unused_upper = ^bus.in_data[N-1:16];
    end

    always_comb begin
        w_op_mag   = bus.in_data[14:0];
        // -0 on input behaves as +0 so that equal-magnitude cancellation stays positive
        w_op_sign  = bus.in_data[15] & (w_op_mag != 15'd0);
`ifdef SM_ACC_SAT_EN
        w_add      = {1'b0, r_acc_mag} + {1'b0, w_op_mag};
`else
        w_add      = r_acc_mag + w_op_mag;
`endif
        w_sum_sign = r_acc_sign;
        w_sum_mag  = r_acc_mag;
        w_sat_next = r_sat;
        if (r_acc_sign == w_op_sign) begin
`ifdef SM_ACC_SAT_EN
            if (w_add[15]) begin
                w_sum_mag  = 15'h7fff;
                w_sat_next = 1'b1;
            end else begin
                w_sum_mag  = w_add[14:0];
            end
`else
            w_sum_mag = w_add;
`endif
        end else if (r_acc_mag >= w_op_mag) begin
            w_sum_mag  = r_acc_mag - w_op_mag;
        end else begin
            w_sum_mag  = w_op_mag - r_acc_mag;
            w_sum_sign = w_op_sign;
        end
        if (w_sum_mag == 15'd0) begin
            w_sum_sign = 1'b0;
        end
        w_cnt_next = (&r_count) ? r_count : r_count + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StAcc;
            r_acc_sign  <= 1'b0;
            r_acc_mag   <= '0;
            r_count     <= '0;
            r_sat       <= 1'b0;
            r_out_data  <= '0;
            r_out_zero  <= 1'b0;
            r_out_neg   <= 1'b0;
            r_out_sat   <= 1'b0;
            r_out_count <= '0;
        end else begin
            unique case (r_state)
                StAcc: begin
                    if (bus.in_valid) begin
                        r_acc_sign <= w_sum_sign;
                        r_acc_mag  <= w_sum_mag;
                        r_count    <= w_cnt_next;
                        r_sat      <= w_sat_next;
                        if (bus.in_last) begin
                            r_state     <= StOut;
                            r_out_data  <= N'({w_sum_sign, w_sum_mag});
                            r_out_zero  <= (w_sum_mag == 15'd0);
                            r_out_neg   <= w_sum_sign;
                            r_out_sat   <= w_sat_next;
                            r_out_count <= w_cnt_next;
                        end
                    end
                end
                StOut: begin
                    if (bus.out_ready) begin
                        r_state     <= StAcc;
                        r_acc_sign  <= 1'b0;
                        r_acc_mag   <= '0;
                        r_count     <= '0;
                        r_sat       <= 1'b0;
                        r_out_data  <= '0;
                        r_out_zero  <= 1'b0;
                        r_out_neg   <= 1'b0;
                        r_out_sat   <= 1'b0;
                        r_out_count <= '0;
                    end
                end
                default: r_state <= StAcc;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == StAcc);
    assign bus.out_valid = (r_state == StOut);
    assign bus.out_data  = r_out_data;
    assign bus.out_zero  = r_out_zero;
    assign bus.out_neg   = r_out_neg;
    assign bus.out_sat   = r_out_sat;
    assign bus.out_count = r_out_count;
endmodule

// File: tb/tb_sm_accumulator.sv
// Bench for sm_accumulator: integer-arithmetic reference model checked every cycle,
// plus directed bursts with hand-computed results.
module tb_sm_accumulator;
    localparam int unsigned N    = 32;
    localparam int unsigned CW   = 8;
    localparam int          CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    sm_accumulator_if #(.N(N), .CW(CW)) bus ();
    sm_accumulator #(.N(N), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: burst sum kept as a plain signed integer.
    bit m_out;
    int m_acc;
    int m_cnt;
    bit m_sat;

    function automatic int sm_val(input logic [31:0] w);
        int mag;
        mag = int'(w[14:0]);
        return w[15] ? -mag : mag;
    endfunction

    function automatic bit ovf(input int a, input logic [31:0] w);
        int s;
        s = a + sm_val(w);
        return (s > 32767) || (s < -32767);
    endfunction

    function automatic int acc_add(input int a, input logic [31:0] w);
        int s;
        s = a + sm_val(w);
        if (ovf(a, w)) begin
`ifdef SM_ACC_SAT_EN
            s = (s > 0) ? 32767 : -32767;
`else
            s = (s > 0) ? (s % 32768) : -((-s) % 32768);
`endif
        end
        return s;
    endfunction

    function automatic logic [31:0] sm_enc(input int v);
        int   mag;
        logic neg;
        mag = (v < 0) ? -v : v;
        neg = (v < 0);
        if (mag == 0) return 32'h0;
        return {16'h0, neg, mag[14:0]};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_out <= 1'b0;
            m_acc <= 0;
            m_cnt <= 0;
            m_sat <= 1'b0;
        end else if (!m_out) begin
            if (bus.in_valid) begin
                m_acc <= acc_add(m_acc, bus.in_data);
                m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
`ifdef SM_ACC_SAT_EN
                m_sat <= m_sat | ovf(m_acc, bus.in_data);
`endif
                m_out <= bus.in_last;
            end
        end else if (bus.out_ready) begin
            m_out <= 1'b0;
            m_acc <= 0;
            m_cnt <= 0;
            m_sat <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(!m_out));
        chk("out_valid", 32'(bus.out_valid), 32'(m_out));
        if (m_out) begin
            chk("out_data", bus.out_data, sm_enc(m_acc));
            chk("out_zero", 32'(bus.out_zero), 32'(m_acc == 0));
            chk("out_neg", 32'(bus.out_neg), 32'(m_acc < 0));
            chk("out_sat", 32'(bus.out_sat), 32'(m_sat));
            chk("out_count", 32'(bus.out_count), 32'(m_cnt));
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!bus.in_ready && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) chk("timeout_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!bus.out_valid && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (!bus.out_valid) chk("timeout_out_valid", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic send(input logic [31:0] d, input logic last, input logic ordy);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_last   = last;
        bus.out_ready = ordy;
        wait_ready();
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic expect_res(input string nm, input logic [31:0] d, input logic [31:0] z,
                              input logic [31:0] n, input logic [31:0] s, input logic [31:0] c);
        wait_valid();
        chk({nm, "_data"}, bus.out_data, d);
        chk({nm, "_zero"}, 32'(bus.out_zero), z);
        chk({nm, "_neg"}, 32'(bus.out_neg), n);
        chk({nm, "_sat"}, 32'(bus.out_sat), s);
        chk({nm, "_count"}, 32'(bus.out_count), c);
    endtask

    task automatic consume(input int hold);
        repeat (hold) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({nm, "_data"}, bus.out_data, 32'd0);
        chk({nm, "_zero"}, 32'(bus.out_zero), 32'd0);
        chk({nm, "_neg"}, 32'(bus.out_neg), 32'd0);
        chk({nm, "_sat"}, 32'(bus.out_sat), 32'd0);
        chk({nm, "_count"}, 32'(bus.out_count), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        bit          pend;
        int          len;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

        send(32'h0005, 1'b0, 1'b0);
        send(32'h0003, 1'b0, 1'b0);
        send(32'h8002, 1'b1, 1'b0);
        idle();
        expect_res("sum3", 32'h6, 0, 0, 0, 3);
        consume(2);

        send(32'h0004, 1'b0, 1'b0);
        send(32'h8004, 1'b1, 1'b0);
        idle();
        expect_res("cancel", 32'h0, 1, 0, 0, 2);
        consume(0);
        send(32'h8000, 1'b1, 1'b0);
        idle();
        expect_res("negzero", 32'h0, 1, 0, 0, 1);
        consume(1);

        send(32'h7000, 1'b0, 1'b0);
        send(32'h1500, 1'b1, 1'b0);
        idle();
`ifdef SM_ACC_SAT_EN
        expect_res("overflow", 32'h7fff, 0, 0, 1, 2);
`else
        expect_res("overflow", 32'h0500, 0, 0, 0, 2);
`endif
        consume(0);

        // Backpressure with an operand already waiting upstream
        send(32'h0007, 1'b1, 1'b0);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0100;
        bus.in_last   = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", bus.out_data, 32'h7);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_ready_after", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        idle();
        expect_res("bp_next", 32'h0100, 0, 0, 0, 1);
        consume(0);

        send(32'h8009, 1'b0, 1'b0);
        send(32'h0002, 1'b0, 1'b0);
        send(32'h8001, 1'b1, 1'b0);
        idle();
        expect_res("neg", 32'h8008, 0, 1, 0, 3);
        consume(0);
        send(32'hffff0003, 1'b1, 1'b0);
        idle();
        expect_res("upper", 32'h3, 0, 0, 0, 1);
        consume(0);

        send(32'h0001, 1'b0, 1'b0);
        send(32'h0002, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1 check_idle_outputs("rst_mid");
        idle();
        rst = 1'b1;
        send(32'h0009, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1 check_idle_outputs("rst_out");
        idle();
        rst = 1'b1;
        send(32'h0001, 1'b1, 1'b0);
        idle();
        expect_res("after_rst", 32'h1, 0, 0, 0, 1);
        consume(0);

        // Last beat lands after the count has already saturated
        for (int i = 0; i < 256; i++) send(32'h0001, (i == 255), 1'b0);
        idle();
        expect_res("cnt_sat", 32'h100, 0, 0, 0, CMAX);
        consume(0);

        for (int b = 0; b < 200; b++) begin
            len = int'($urandom_range(1, 6));
            for (int j = 0; j < len; j++) begin
                if ($urandom % 4 == 0) begin
                    idle();
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                d[31:16] = 16'($urandom);
                d[15]    = 1'($urandom);
                d[14:0]  = ($urandom % 2 == 1) ? 15'($urandom_range(16'h5000, 16'h7fff))
                                               : 15'($urandom_range(0, 32));
                if ($urandom % 16 == 0) d[14:0] = 15'h0;
                send(d, (j == len - 1), (j == len - 1) ? 1'b0 : 1'($urandom));
            end
            idle();
            wait_valid();
            pend = 1'($urandom);
            if (pend) begin
                bus.in_valid = 1'b1;
                bus.in_data  = $urandom;
                bus.in_last  = 1'b0;
            end
            consume(int'($urandom_range(0, 3)));
            if (pend) @(posedge clk);
        end
        idle();
        send(32'h0000, 1'b1, 1'b0);
        idle();
        wait_valid();
        consume(0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sm_accumulator.md
Name: sm_accumulator

Overview:
- Streaming reduction stage directly downstream of the 16-bit sign-magnitude adder datapath.
- Accepts a burst of sign-magnitude operands via valid/ready and accumulates them: word bit 15 = sign, bits 14:0 = magnitude, bits N-1:16 ignored on input and driven 0 on output.
- On the beat flagged last, presents the final sum with zero/neg/saturation flags and element count, held until the consumer takes it.
- Used for dot-product and vector-sum reductions.

Parameters:
- N, 32, data word width; must be >= 16.
- CW, 8, element counter width; count saturates at 2^CW-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  stage can accept an operand.
- in_data  in  N  sign-magnitude operand.
- in_last  in  1  final operand of the burst; qualified by in_valid.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  N  accumulated sum in sign-magnitude.
- out_zero  out  1  out_data magnitude == 0.
- out_neg  out  1  equals out_data[15].
- out_sat  out  1  saturation occurred in this burst (sticky per burst).
- out_count  out  CW  number of operands accepted in the burst.

Behaviour:
- Reset (rst low, asynchronous):
  - Accumulator is +0, count is 0, sat is 0, state is ACC.
  - out_valid, out_data, out_zero, out_neg, out_sat and out_count are all 0.
  - in_ready is 1 on the first edge after deassertion.
- FSM has two states: ACC and OUT.
- ACC state:
  - in_ready = 1, out_valid = 0.
  - A beat is accepted on in_valid & in_ready: acc <= acc (+) in_data[15:0], and count increments (saturating at 2^CW-1).
  - If in_last is set on the accepted beat, move to OUT. The result is visible with out_valid = 1 on the next cycle (1-cycle latency).
- OUT state:
  - in_ready = 0, out_valid = 1.
  - Outputs are registered and stable while out_valid & ~out_ready.
  - On out_ready: acc, count and sat clear and the state returns to ACC. in_ready is 1 in the following cycle, so there is one bubble per burst.
- Sign-magnitude add (+), on 15-bit magnitudes:
  - Same signs: magnitudes add and the sign is kept.
  - Different signs: the larger magnitude minus the smaller, with the sign of the larger.
  - Equal magnitudes with different signs give +0.
- Zero normalisation: every stored result with magnitude 0 has sign 0. An input of -0 (0x8000) is treated as +0, and out_neg is never 1 when out_zero is 1.
- Overflow: the magnitude sum exceeds 0x7FFF only when signs are the same. Handling depends on SM_ACC_SAT_EN (see Optional Feature).
- A single-beat burst (in_last on the first beat) gives a result equal to the normalised operand with count 1.
- in_last on the same beat as count saturation: the beat is still accepted, the sum is updated and count stays at max.
- out_ready asserted while in ACC is ignored.
- in_valid asserted while in OUT is not accepted; the upstream holds it.
- Reset mid-burst or during OUT discards the partial sum and drops out_valid immediately (asynchronously).
- out_data[N-1:16] is always 0.

Optional Feature:
- Macro: SM_ACC_SAT_EN.
- Defined:
  - On overflow, the magnitude clamps to 0x7FFF with the operand sign.
  - The sat flag sets and stays set until the result is consumed.
  - Later beats continue from the clamped value.
- Undefined:
  - The magnitude wraps modulo 2^15 and the sign is kept.
  - If the wrapped magnitude is 0, the sign is normalised to 0.
  - out_sat is tied to 0.

Test Plan:
- Reset released, burst 0x0005, 0x0003, 0x8002(last) -> one cycle after the last beat: out_valid=1, out_data=0x00000006, out_zero=0, out_neg=0, out_count=3.
- Burst 0x0004, 0x8004(last) -> out_data=0x00000000, out_zero=1, out_neg=0 (no -0); single-beat 0x8000(last) -> out_data=0, out_count=1.
- SM_ACC_SAT_EN defined, burst 0x7000, 0x1500(last) -> out_data=0x00007FFF, out_sat=1. Undefined -> out_data=0x00000500, out_sat=0.
- Backpressure: hold out_ready=0 for 5 cycles during OUT -> outputs stable, in_ready=0, pending in_valid not accepted. Raise out_ready -> in_ready=1 in the next cycle and the next burst starts from +0.
- Burst 0x8009, 0x0002, 0x8001(last) -> out_data=0x00008008, out_neg=1; upper input bits set (0xFFFF0003) are ignored.
- Assert rst low mid-burst after 2 beats -> all outputs 0 immediately. New burst 0x0001(last) -> out_data=1, out_count=1.
